// File: rtl/console_uart_tx.sv
// console_uart_tx: byte FIFO fed by the console send handshake, drained by an 8N1 serializer.
// States: IDLE | line high, waiting for a byte; START | start bit; DATA | 8 data bits LSB first; STOP | stop bit.
module console_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    i_data,
  input  logic                          i_hsreq,
  output logic                          o_hsack,
  output logic                          o_txd,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_drop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [7:0]  shift;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        bit_done;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign o_level  = wr_ptr - rd_ptr;
  assign o_hsack  = ~full;
  assign o_drop   = i_hsreq & full;
  assign push     = i_hsreq & ~full;
  assign bit_done = (timer == '0);
  // A pop in STOP chains the next frame with no idle gap.
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign o_busy   = (state != IDLE) | ~empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      o_txd <= 1'b1;
      shift <= '0;
      timer <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr[AW-1:0]];
            o_txd <= 1'b0;
            timer <= BIT_LAST;
            state <= START;
          end else begin
            o_txd <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            o_txd <= shift[0];
            timer <= BIT_LAST;
            idx   <= '0;
            state <= DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= BIT_LAST;
            if (idx == 3'd7) begin
              o_txd <= 1'b1;
              state <= STOP;
            end else begin
              shift <= {1'b0, shift[7:1]};
              o_txd <= shift[1];
              idx   <= idx + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift <= mem[rd_ptr[AW-1:0]];
              o_txd <= 1'b0;
              timer <= BIT_LAST;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: accepted bytes are queued as expected frames, a UART
// monitor decodes o_txd cycle by cycle and compares against the queue.
module tb_console_uart_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [7:0] i_data;
  logic       i_hsreq;
  logic       o_hsack;
  logic       o_txd;
  logic       o_busy;
  logic [2:0] o_level;
  logic       o_drop;

  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         n_frames = 0;
  int         n_checks = 0;
  int         n_err = 0;
  bit         mon_abort = 0;

  console_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .i_data(i_data), .i_hsreq(i_hsreq),
    .o_hsack(o_hsack), .o_txd(o_txd), .o_busy(o_busy), .o_level(o_level), .o_drop(o_drop)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (o_busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(!o_busy, name, o_busy, 0);
    step();
  endtask

  // A transfer happens at the next posedge when these hold at the preceding negedge.
  always @(negedge clock) begin
    if (reset && i_hsreq && o_hsack) begin
      exp_q.push_back(i_data);
      acc_cnt++;
    end
  end

  initial begin : uart_mon
    logic       prev;
    logic [7:0] exp_b;
    logic [7:0] got;
    logic       eb;
    int         bad;
    int         slot;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (prev && !o_txd && !mon_abort) begin
        aborted = 0;
        bad = 0;
        got = '0;
        check(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        for (int c = 0; c < 10*DIV; c++) begin
          if (c > 0) @(negedge clock);
          if (mon_abort) begin
            aborted = 1;
            break;
          end
          slot = c / DIV;
          eb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : exp_b[slot-1];
          if (o_txd !== eb) bad++;
          if (slot >= 1 && slot <= 8 && (c % DIV) == DIV/2) got[slot-1] = o_txd;
        end
        if (!aborted) begin
          check(got == exp_b, "frame_data", got, exp_b);
          check(bad == 0, "frame_shape", bad, 0);
          n_frames++;
          prev = o_txd;
        end else begin
          prev = 1'b0;
        end
      end else begin
        prev = o_txd;
      end
    end
  end

  initial begin : stim
    int         a0;
    int         drops;
    bit         acc;
    bit         ok;
    logic [7:0] b0;
    reset = 1'b0;
    i_hsreq = 1'b0;
    i_data = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check(o_txd == 1'b1, "rst_txd", o_txd, 1);
    check(o_level == 3'd0, "rst_level", o_level, 0);
    check(o_busy == 1'b0, "rst_busy", o_busy, 0);
    check(o_drop == 1'b0, "rst_drop", o_drop, 0);
    check(o_hsack == 1'b1, "rst_hsack", o_hsack, 1);
    step();
    reset = 1'b1;
    repeat (2) step();

    // single byte: latency and frame length
    i_hsreq = 1'b1;
    i_data = 8'hA5;
    step();
    i_hsreq = 1'b0;
    @(negedge clock);
    check(o_txd == 1'b1, "t1_txd_pre", o_txd, 1);
    check(o_level == 3'd1, "t1_level", o_level, 1);
    check(o_busy == 1'b1, "t1_busy", o_busy, 1);
    @(negedge clock);
    check(o_txd == 1'b0, "t1_start", o_txd, 0);
    check(o_level == 3'd0, "t1_popped", o_level, 0);
    repeat (39) @(negedge clock);
    check(o_busy == 1'b1, "t1_busy_last", o_busy, 1);
    check(o_txd == 1'b1, "t1_stop", o_txd, 1);
    @(negedge clock);
    check(o_busy == 1'b0, "t1_idle", o_busy, 0);
    wait_idle(100, "t1_wait");

    // back-to-back frames without an idle gap
    i_hsreq = 1'b1;
    i_data = 8'h00;
    step();
    i_data = 8'hFF;
    step();
    i_hsreq = 1'b0;
    repeat (40) @(negedge clock);
    check(o_txd == 1'b1, "t2_stop1", o_txd, 1);
    @(negedge clock);
    check(o_txd == 1'b0, "t2_no_gap", o_txd, 0);
    repeat (39) @(negedge clock);
    check(o_busy == 1'b1, "t2_busy_last", o_busy, 1);
    @(negedge clock);
    check(o_busy == 1'b0, "t2_idle", o_busy, 0);
    wait_idle(100, "t2_wait");

    // hold request 6 cycles into a depth-4 FIFO
    a0 = acc_cnt;
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      i_hsreq = 1'b1;
      i_data = 8'($urandom);
      @(negedge clock);
      if (o_drop) drops++;
      step();
    end
    i_hsreq = 1'b0;
    @(negedge clock);
    check(acc_cnt - a0 == 5, "t3_accepted", acc_cnt - a0, 5);
    check(drops == 1, "t3_drops", drops, 1);
    check(o_hsack == 1'b0, "t3_hsack", o_hsack, 0);
    check(o_level == 3'd4, "t3_level", o_level, 4);

    // push attempt on the edge where the stop bit pops the next byte
    repeat (35) @(posedge clock);
    #1;
    i_hsreq = 1'b1;
    i_data = 8'h77;
    @(negedge clock);
    check(o_drop == 1'b1, "t4_drop", o_drop, 1);
    check(o_level == 3'd4, "t4_level_full", o_level, 4);
    step();
    i_hsreq = 1'b0;
    @(negedge clock);
    check(o_level == 3'd3, "t4_level", o_level, 3);
    check(acc_cnt - a0 == 5, "t4_refused", acc_cnt - a0, 5);
    wait_idle(400, "t4_wait");

    // reset during data bit 3
    b0 = 8'($urandom);
    i_hsreq = 1'b1;
    i_data = b0;
    step();
    i_data = 8'($urandom);
    step();
    i_data = 8'($urandom);
    step();
    i_hsreq = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    mon_abort = 1'b1;
    @(negedge clock);
    check(o_txd == b0[3], "t5_bit3", o_txd, b0[3]);
    step();
    exp_q.delete();
    @(negedge clock);
    check(o_txd == 1'b1, "t5_txd", o_txd, 1);
    check(o_level == 3'd0, "t5_level", o_level, 0);
    check(o_busy == 1'b0, "t5_busy", o_busy, 0);
    check(o_drop == 1'b0, "t5_drop", o_drop, 0);
    step();
    reset = 1'b1;
    repeat (2) step();
    mon_abort = 1'b0;
    check(o_hsack == 1'b1, "t5_hsack", o_hsack, 1);
    i_hsreq = 1'b1;
    i_data = 8'h3C;
    step();
    i_hsreq = 1'b0;
    wait_idle(100, "t5_wait");

    // randomized stream with gaps
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 50)) step();
      i_hsreq = 1'b1;
      i_data = 8'($urandom);
      ok = 0;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clock);
        acc = o_hsack;
        step();
        if (acc) begin
          ok = 1;
          break;
        end
      end
      i_hsreq = 1'b0;
      if (!ok) check(ok, "t6_accept_timeout", k, 1);
    end
    wait_idle(1000, "t6_wait");
    repeat (4) step();
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    check(n_frames == 209, "frame_count", n_frames, 209);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
